// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    localparam int DEF_MEM_LAT    = 4;
    localparam int DEF_STARVE_MAX = 2;
    localparam int CNT_W          = 4;
    localparam int STREAK_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        GAP    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Access latency counter: clear on grant, count while busy, flag the last cycle.
module mem_lat_counter
    import mem_arbiter_pkg::*;
#(
    parameter int LAT = DEF_MEM_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(LAT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single fixed-latency memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out
);

    localparam logic [STREAK_W-1:0] SMAX = STREAK_W'(STARVE_MAX);

    arb_state_e          state_q;
    logic [15:0]         addr_q;
    logic [15:0]         wdata_q;
    logic [15:0]         rdata_q;
    logic                wr_q;
    logic                en_q;
    logic                mwr_q;
    logic [STREAK_W-1:0] streak_q;

    logic in_busy;
    logic grant;
    logic d_win;
    logic tc;

    assign in_busy = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign grant   = (state_q == IDLE) && (i_req || d_req);
    // Data normally wins; a waiting fetch wins once data has had its streak.
    assign d_win   = d_req && !(i_req && (streak_q == SMAX));

    mem_lat_counter #(
        .LAT (MEM_LAT)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (grant),
        .en_i  (in_busy),
        .tc_o  (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wr_q     <= 1'b0;
            en_q     <= 1'b0;
            mwr_q    <= 1'b0;
            streak_q <= '0;
        end else begin
            en_q  <= 1'b0;
            mwr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (d_win) begin
                        state_q <= BUSY_D;
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        wr_q    <= d_wr;
                        en_q    <= 1'b1;
                        mwr_q   <= d_wr;
                        if (!i_req) begin
                            streak_q <= '0;
                        end else if (streak_q != SMAX) begin
                            streak_q <= streak_q + 1'b1;
                        end
                    end else if (i_req) begin
                        state_q  <= BUSY_I;
                        addr_q   <= i_addr;
                        wdata_q  <= '0;
                        wr_q     <= 1'b0;
                        en_q     <= 1'b1;
                        streak_q <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (tc) begin
                        state_q <= GAP;
                        if (!wr_q) begin
                            rdata_q <= mem_data_out;
                        end
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_done      = (state_q == BUSY_I) && tc;
    assign d_done      = (state_q == BUSY_D) && tc;
    assign busy        = (state_q != IDLE);
    assign rdata       = rdata_q;
    assign mem_enable  = en_q;
    assign mem_wr      = mwr_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: default build plus a MEM_LAT=2 build.
module tb_mem_arbiter;

    typedef struct {
        bit          is_d;
        logic [15:0] rd;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        i_done, d_done, busy, mem_enable, mem_wr;
    logic [15:0] rdata, mem_addr, mem_data_in, mem_data_out;

    logic        i_req2 = 1'b0;
    logic        i_done2, d_done2, busy2, mem_enable2, mem_wr2;
    logic [15:0] rdata2, mem_addr2, mem_data_in2, mem_data_out2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    int   wr_cnt = 0;
    exp_t q[$];

    logic [15:0] wmem [256];
    bit          wval [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_done(d_done),
        .rdata(rdata), .busy(busy),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    mem_arbiter #(.MEM_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req2), .i_addr(16'h0010), .i_done(i_done2),
        .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000),
        .d_wdata(16'h0000), .d_done(d_done2),
        .rdata(rdata2), .busy(busy2),
        .mem_enable(mem_enable2), .mem_wr(mem_wr2),
        .mem_addr(mem_addr2), .mem_data_in(mem_data_in2),
        .mem_data_out(mem_data_out2)
    );

    function automatic logic [15:0] init_word(input logic [7:0] a);
        case (a)
            8'h10:   return 16'h1234;
            8'h20:   return 16'h5555;
            8'h44:   return 16'hAAAA;
            default: return {8'hC0, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_enable && mem_wr) begin
            wmem[mem_addr[7:0]] <= mem_data_in;
            wval[mem_addr[7:0]] <= 1'b1;
        end
    end

    assign mem_data_out = wval[mem_addr[7:0]] ? wmem[mem_addr[7:0]]
                                              : init_word(mem_addr[7:0]);
    assign mem_data_out2 = init_word(mem_addr2[7:0]);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit is_d, input logic [15:0] rd,
                        input int c);
        exp_t e;
        e.is_d = is_d;
        e.rd   = rd;
        e.cyc  = c;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per done pulse; rdata checked next cycle.
    initial begin
        bit          rd_pend = 1'b0;
        logic [15:0] rd_exp = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (mem_enable) en_cnt++;
            if (mem_wr) wr_cnt++;
            if (rd_pend) begin
                chk("rdata", {16'h0, rdata}, {16'h0, rd_exp});
                rd_pend = 1'b0;
            end
            if (i_done || d_done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: i=%0b d=%0b cyc=%0d",
                             i_done, d_done, cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_kind", {30'h0, d_done, i_done},
                        {30'h0, e.is_d, !e.is_d});
                    chk("done_cycle", cyc, e.cyc);
                    rd_pend = 1'b1;
                    rd_exp  = e.rd;
                end
            end
        end
    end

    task automatic wait_done(input int n);
        int seen = 0;
        for (int k = 0; k < 60 && seen < n; k++) begin
            @(negedge clk);
            if (i_done || d_done) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d dones expected %0d", seen, n);
        end
    endtask

    task automatic issue_slot(output int c);
        repeat (3) @(posedge clk);
        #1;
        c = cyc;
    endtask

    initial begin
        int c;
        int e0, w0;
        int en2[$];
        int dn2[$];

        #3;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_en", {30'h0, mem_enable, mem_wr}, 32'h0);
        chk("rst_done", {30'h0, i_done, d_done}, 32'h0);
        chk("rst_rdata", {16'h0, rdata}, 32'h0);
        chk("rst_addr", {mem_addr, mem_data_in}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch only
        issue_slot(c);
        e0 = en_cnt;
        i_req  = 1'b1;
        i_addr = 16'h0010;
        push(1'b0, 16'h1234, c + 4);
        @(negedge clk);
        chk("fetch_prebusy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("fetch_busy", {31'h0, busy}, 32'h1);
        chk("fetch_en", {30'h0, mem_enable, mem_wr}, 32'h2);
        chk("fetch_addr", {16'h0, mem_addr}, 32'h0010);
        wait_done(1);
        i_req = 1'b0;

        // Store
        issue_slot(c);
        e0 = en_cnt;
        w0 = wr_cnt;
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 16'h0040;
        d_wdata = 16'hBEEF;
        push(1'b1, 16'h1234, c + 4);
        wait_done(1);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("store_en_pulses", en_cnt - e0, 1);
        chk("store_wr_pulses", wr_cnt - w0, 1);
        chk("store_mem", {16'h0, wmem[8'h40]}, 32'hBEEF);

        // Load back the stored word
        issue_slot(c);
        d_req = 1'b1;
        d_wr  = 1'b0;
        push(1'b1, 16'hBEEF, c + 4);
        wait_done(1);
        d_req = 1'b0;

        // Simultaneous requests: data first, fetch after the gap
        issue_slot(c);
        i_req  = 1'b1;
        i_addr = 16'h0020;
        d_req  = 1'b1;
        d_addr = 16'h0044;
        push(1'b1, 16'hAAAA, c + 4);
        push(1'b0, 16'h5555, c + 10);
        wait_done(1);
        d_req = 1'b0;
        wait_done(1);
        i_req = 1'b0;

        // Both held: D,D,I,D,D,I
        issue_slot(c);
        i_req = 1'b1;
        d_req = 1'b1;
        push(1'b1, 16'hAAAA, c + 4);
        push(1'b1, 16'hAAAA, c + 10);
        push(1'b0, 16'h5555, c + 16);
        push(1'b1, 16'hAAAA, c + 22);
        push(1'b1, 16'hAAAA, c + 28);
        push(1'b0, 16'h5555, c + 34);
        wait_done(6);
        i_req = 1'b0;
        d_req = 1'b0;

        // Reset in the second busy cycle
        issue_slot(c);
        i_req  = 1'b1;
        i_addr = 16'h0010;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_en", {30'h0, mem_enable, mem_wr}, 32'h0);
        chk("mid_rst_done", {30'h0, i_done, d_done}, 32'h0);
        chk("mid_rst_rdata", {16'h0, rdata}, 32'h0);
        chk("mid_rst_addr", {16'h0, mem_addr}, 32'h0);
        repeat (3) @(negedge clk);
        push(1'b0, 16'h1234, cyc + 4);
        rst_n = 1'b1;
        wait_done(1);
        i_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        // MEM_LAT=2 build, back-to-back fetches
        issue_slot(c);
        i_req2 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (mem_enable2) en2.push_back(cyc);
            if (i_done2) dn2.push_back(cyc);
        end
        i_req2 = 1'b0;
        chk("l2_grants", en2.size(), 3);
        chk("l2_dones", dn2.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < en2.size()) chk("l2_grant_cyc", en2[k], c + 1 + 4 * k);
            if (k < dn2.size()) chk("l2_done_cyc", dn2[k], c + 2 + 4 * k);
        end
        @(negedge clk);
        chk("l2_rdata", {16'h0, rdata2}, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
